// File: rtl/alarm_pkg.sv
// Shared types, BCD constants and helpers for the alarm bank.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_0 = 4'd0;
   localparam logic [3:0] BCD_1 = 4'd1;
   localparam logic [3:0] BCD_2 = 4'd2;
   localparam logic [3:0] BCD_5 = 4'd5;
   localparam logic [3:0] BCD_9 = 4'd9;

   typedef struct packed {
      logic [3:0] hour_t;
      logic [3:0] hour_u;
      logic [3:0] min_t;
      logic [3:0] min_u;
   } hhmm_t;

   function automatic int unsigned sel_w(int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Minutes {tens,units} +1, 59 wraps to 00 with no carry out.
   function automatic logic [7:0] inc_min(logic [7:0] m);
      if (m[3:0] == BCD_9)
         return (m[7:4] == BCD_5) ? 8'h00 : {m[7:4] + 4'd1, BCD_0};
      return {m[7:4], m[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_hour(logic [7:0] h, logic mode_12h);
      if (mode_12h) begin
         if (h == 8'h12) return 8'h01;
      end else if (h == 8'h23) begin
         return 8'h00;
      end
      if (h[3:0] == BCD_9) return {h[7:4] + 4'd1, BCD_0};
      return {h[7:4], h[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational HH:MM (BCD) plus a constant number of minutes, hour wrap per clock mode.
module bcd_time_add
   import alarm_pkg::*;
#(
   parameter int unsigned ADD_MIN  = 5,
   parameter bit          MODE_12H = 1'b0
) (
   input  hhmm_t t_in,
   output hhmm_t t_out
);

   logic [6:0] min_bin;
   logic [6:0] min_sum;
   logic [4:0] hr_bin;
   logic [4:0] hr_next;

   always_comb begin
      min_bin = 7'(t_in.min_t) * 7'd10 + 7'(t_in.min_u);
      hr_bin  = 5'(t_in.hour_t) * 5'd10 + 5'(t_in.hour_u);
      min_sum = min_bin + 7'(ADD_MIN);
      hr_next = hr_bin;
      if (min_sum >= 7'd60) begin
         min_sum = min_sum - 7'd60;
         if (MODE_12H) hr_next = (hr_bin == 5'd12) ? 5'd1 : hr_bin + 5'd1;
         else          hr_next = (hr_bin == 5'd23) ? 5'd0 : hr_bin + 5'd1;
      end
      t_out.hour_t = 4'(hr_next / 5'd10);
      t_out.hour_u = 4'(hr_next % 5'd10);
      t_out.min_t  = 4'(min_sum / 7'd10);
      t_out.min_u  = 4'(min_sum % 7'd10);
   end

endmodule

// File: rtl/alarm_bank.sv
// N-channel BCD alarm registers with per-channel enable, edge-triggered match
// and one shared ring/snooze/stop controller.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter int unsigned NUM_ALARMS = 4,
   parameter int unsigned SNOOZE_MIN = 5,
   parameter int unsigned RING_TICKS = 600,
   parameter bit          MODE_12H   = 1'b0,
   localparam int unsigned SELW      = sel_w(NUM_ALARMS)
) (
   input  logic                  clk10hz,
   input  logic                  rst,
   input  logic [SELW-1:0]       sel,
   input  logic                  setM,
   input  logic                  setH,
   input  logic [NUM_ALARMS-1:0] alarmEn,
   input  logic [3:0]            curHourTens,
   input  logic [3:0]            curHourMu,
   input  logic [3:0]            curMinTens,
   input  logic [3:0]            curMinMu,
   input  logic                  stopBtn,
   input  logic                  snoozeBtn,
   output logic [3:0]            alarmHourTens,
   output logic [3:0]            alarmHourMu,
   output logic [3:0]            alarmMinTens,
   output logic [3:0]            alarmMinMu,
   output logic                  ring,
   output logic [SELW-1:0]       ringCh,
   output logic                  snoozing
);

   localparam int unsigned CNTW = $clog2(RING_TICKS + 1);
   localparam hhmm_t RST_TIME = MODE_12H ? hhmm_t'({BCD_1, BCD_2, BCD_0, BCD_0}) : hhmm_t'(16'h0000);

   hhmm_t                  cur_c;
   hhmm_t                  alarm_all [NUM_ALARMS];
   hhmm_t                  rd_c;
   hhmm_t                  snooze_tgt_c;
   logic [NUM_ALARMS-1:0]  match_c;
   logic [NUM_ALARMS-1:0]  trig_c;
   logic [NUM_ALARMS-1:0]  match_prev_d, match_prev_q;
   logic                   any_trig_c;
   logic [SELW-1:0]        trig_idx_c;
   logic                   ch_en_c;

   state_t                 state_d, state_q;
   logic [SELW-1:0]        ring_ch_d, ring_ch_q;
   logic [CNTW-1:0]        ring_cnt_d, ring_cnt_q;
   hhmm_t                  target_d, target_q;
   logic                   ring_d, ring_q;
   logic                   snoozing_d, snoozing_q;

   assign cur_c = '{hour_t: curHourTens, hour_u: curHourMu, min_t: curMinTens, min_u: curMinMu};

   // Per-channel alarm register, set logic and match detection.
   for (genvar i = 0; i < NUM_ALARMS; i++) begin : gen_ch
      hhmm_t alarm_d, alarm_q;
      logic  setting_c;

      assign setting_c = (sel == SELW'(i)) && (setM || setH);

      always_comb begin
         alarm_d = alarm_q;
         if (sel == SELW'(i)) begin
            if (setM) {alarm_d.min_t, alarm_d.min_u}   = inc_min({alarm_q.min_t, alarm_q.min_u});
            if (setH) {alarm_d.hour_t, alarm_d.hour_u} = inc_hour({alarm_q.hour_t, alarm_q.hour_u}, MODE_12H);
         end
      end

      always_ff @(posedge clk10hz) begin
         if (rst) alarm_q <= RST_TIME;
         else     alarm_q <= alarm_d;
      end

      assign alarm_all[i] = alarm_q;
      assign match_c[i]   = alarmEn[i] && (alarm_q == cur_c) && !setting_c;
   end

   assign trig_c       = match_c & ~match_prev_q;
   assign match_prev_d = match_c;

   // Read mux, lowest-index trigger encoder and enable of the latched channel.
   always_comb begin
      rd_c       = '0;
      any_trig_c = 1'b0;
      trig_idx_c = '0;
      ch_en_c    = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (sel == SELW'(i))       rd_c    = alarm_all[i];
         if (ring_ch_q == SELW'(i)) ch_en_c = alarmEn[i];
      end
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (trig_c[i]) begin
            any_trig_c = 1'b1;
            trig_idx_c = SELW'(i);
         end
      end
   end

   bcd_time_add #(
      .ADD_MIN  (SNOOZE_MIN),
      .MODE_12H (MODE_12H)
   ) u_snooze_add (
      .t_in  (cur_c),
      .t_out (snooze_tgt_c)
   );

   // Ring controller: stop beats snooze beats auto-stop.
   always_comb begin
      state_d    = state_q;
      ring_ch_d  = ring_ch_q;
      ring_cnt_d = ring_cnt_q;
      target_d   = target_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_trig_c) begin
               state_d    = ST_RING;
               ring_ch_d  = trig_idx_c;
               ring_cnt_d = '0;
            end
         end
         ST_RING: begin
            ring_cnt_d = ring_cnt_q + CNTW'(1);
            if (stopBtn) begin
               state_d = ST_IDLE;
            end else if (snoozeBtn) begin
               state_d  = ST_SNOOZE;
               target_d = snooze_tgt_c;
            end else if (ring_cnt_q == CNTW'(RING_TICKS - 1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_SNOOZE: begin
            if (stopBtn || !ch_en_c) begin
               state_d = ST_IDLE;
            end else if (cur_c == target_q) begin
               state_d    = ST_RING;
               ring_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ring_d     = (state_d == ST_RING);
      snoozing_d = (state_d == ST_SNOOZE);
   end

   always_ff @(posedge clk10hz) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ring_ch_q    <= '0;
         ring_cnt_q   <= '0;
         target_q     <= '0;
         ring_q       <= 1'b0;
         snoozing_q   <= 1'b0;
         match_prev_q <= '1;
      end else begin
         state_q      <= state_d;
         ring_ch_q    <= ring_ch_d;
         ring_cnt_q   <= ring_cnt_d;
         target_q     <= target_d;
         ring_q       <= ring_d;
         snoozing_q   <= snoozing_d;
         match_prev_q <= match_prev_d;
      end
   end

   assign alarmHourTens = rd_c.hour_t;
   assign alarmHourMu   = rd_c.hour_u;
   assign alarmMinTens  = rd_c.min_t;
   assign alarmMinMu    = rd_c.min_u;
   assign ring          = ring_q;
   assign ringCh        = ring_ch_q;
   assign snoozing      = snoozing_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: setting table, hand-written ring/snooze
// sequences and a randomized run against a minutes-of-day reference model.
module tb_alarm_bank;

   logic       clk10hz;
   logic       rst;
   logic [1:0] sel;
   logic       setM, setH;
   logic [3:0] alarmEn;
   logic [3:0] curHourTens, curHourMu, curMinTens, curMinMu;
   logic       stopBtn, snoozeBtn;
   logic [3:0] alarmHourTens, alarmHourMu, alarmMinTens, alarmMinMu;
   logic       ring;
   logic [1:0] ringCh;
   logic       snoozing;

   int checks   = 0;
   int failures = 0;

   // Reference model: plain integer hours/minutes, state as 0 idle / 1 ring / 2 snooze.
   int m_h [4];
   int m_m [4];
   bit m_prev [4];
   int m_st, m_ch, m_cnt, m_tgt;
   int cur_h, cur_m;

   typedef struct {
      int sel;
      bit sm;
      bit sh;
      int n;
      int eh;
      int em;
   } vec_t;
   vec_t vecs [10];

   alarm_bank dut (
      .clk10hz       (clk10hz),
      .rst           (rst),
      .sel           (sel),
      .setM          (setM),
      .setH          (setH),
      .alarmEn       (alarmEn),
      .curHourTens   (curHourTens),
      .curHourMu     (curHourMu),
      .curMinTens    (curMinTens),
      .curMinMu      (curMinMu),
      .stopBtn       (stopBtn),
      .snoozeBtn     (snoozeBtn),
      .alarmHourTens (alarmHourTens),
      .alarmHourMu   (alarmHourMu),
      .alarmMinTens  (alarmMinTens),
      .alarmMinMu    (alarmMinMu),
      .ring          (ring),
      .ringCh        (ringCh),
      .snoozing      (snoozing)
   );

   initial begin
      clk10hz = 1'b0;
      forever #5 clk10hz = ~clk10hz;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rd_hhmm();
      return (int'(alarmHourTens) * 10 + int'(alarmHourMu)) * 100 + int'(alarmMinTens) * 10 + int'(alarmMinMu);
   endfunction

   task automatic set_cur(input int h, input int m);
      cur_h = h;
      cur_m = m;
      curHourTens = 4'(h / 10);
      curHourMu   = 4'(h % 10);
      curMinTens  = 4'(m / 10);
      curMinMu    = 4'(m % 10);
   endtask

   task automatic model_step();
      bit mt [4];
      bit st_i;
      int tidx;
      int cur_md;
      cur_md = cur_h * 60 + cur_m;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_h[i] = 0; m_m[i] = 0; m_prev[i] = 1'b1;
         end
         m_st = 0; m_ch = 0; m_cnt = 0; m_tgt = 0;
         return;
      end
      tidx = -1;
      for (int i = 0; i < 4; i++) begin
         st_i  = (int'(sel) == i) && (setM || setH);
         mt[i] = alarmEn[i] && (m_h[i] == cur_h) && (m_m[i] == cur_m) && !st_i;
         if (mt[i] && !m_prev[i] && tidx < 0) tidx = i;
      end
      case (m_st)
         0: if (tidx >= 0) begin m_st = 1; m_ch = tidx; m_cnt = 0; end
         1: begin
            if (stopBtn) m_st = 0;
            else if (snoozeBtn) begin m_st = 2; m_tgt = (cur_md + 5) % 1440; end
            else if (m_cnt == 599) m_st = 0;
            else m_cnt++;
         end
         default: begin
            if (stopBtn || !alarmEn[m_ch]) m_st = 0;
            else if (cur_md == m_tgt) begin m_st = 1; m_cnt = 0; end
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (int'(sel) == i && setM) m_m[i] = (m_m[i] + 1) % 60;
         if (int'(sel) == i && setH) m_h[i] = (m_h[i] + 1) % 24;
         m_prev[i] = mt[i];
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      model_step();
      @(posedge clk10hz);
      #1;
      chk("m_ring", int'(ring), (m_st == 1) ? 1 : 0);
      chk("m_snoozing", int'(snoozing), (m_st == 2) ? 1 : 0);
      chk("m_ringCh", int'(ringCh), m_ch);
      chk("m_alarm_rd", rd_hhmm(), m_h[sel] * 100 + m_m[sel]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_alarm(input int ch, input int h, input int m);
      sel  = 2'(ch);
      setH = 1'b1;
      repeat (h) tick();
      setH = 1'b0;
      setM = 1'b1;
      repeat (m) tick();
      setM = 1'b0;
   endtask

   initial begin
      int n;
      int k;
      rst = 1'b0; sel = 2'd0; setM = 1'b0; setH = 1'b0; alarmEn = 4'd0;
      stopBtn = 1'b0; snoozeBtn = 1'b0;
      set_cur(12, 0);

      vecs[0] = '{2, 1'b0, 1'b1, 13, 13, 0};
      vecs[1] = '{2, 1'b1, 1'b0, 45, 13, 45};
      vecs[2] = '{0, 1'b0, 1'b0, 1, 0, 0};
      vecs[3] = '{1, 1'b0, 1'b0, 1, 0, 0};
      vecs[4] = '{3, 1'b0, 1'b0, 1, 0, 0};
      vecs[5] = '{1, 1'b1, 1'b0, 61, 0, 1};
      vecs[6] = '{1, 1'b0, 1'b1, 25, 1, 1};
      vecs[7] = '{0, 1'b1, 1'b1, 1, 1, 1};
      vecs[8] = '{0, 1'b0, 1'b1, 23, 0, 1};
      vecs[9] = '{2, 1'b0, 1'b0, 1, 13, 45};

      do_reset();
      chk("rst_ring", int'(ring), 0);
      chk("rst_ringCh", int'(ringCh), 0);
      chk("rst_snoozing", int'(snoozing), 0);
      chk("rst_alarm0", rd_hhmm(), 0);

      // Setting table.
      for (int v = 0; v < 10; v++) begin
         sel  = 2'(vecs[v].sel);
         setM = vecs[v].sm;
         setH = vecs[v].sh;
         repeat (vecs[v].n) tick();
         setM = 1'b0;
         setH = 1'b0;
         chk($sformatf("tbl%0d", v), rd_hhmm(), vecs[v].eh * 100 + vecs[v].em);
      end

      // Rising-edge trigger, stop, no re-ring within the minute.
      do_reset();
      set_alarm(1, 7, 30);
      alarmEn = 4'b0010;
      set_cur(7, 29); tick();
      chk("pre_ring", int'(ring), 0);
      set_cur(7, 30); tick();
      chk("trig_ring", int'(ring), 1);
      chk("trig_ch", int'(ringCh), 1);
      stopBtn = 1'b1; tick(); stopBtn = 1'b0;
      chk("stop_ring", int'(ring), 0);
      repeat (5) tick();
      chk("no_rering", int'(ring), 0);

      // Snooze across midnight, then auto-stop after 600 ticks.
      do_reset();
      alarmEn = 4'b0000;
      set_alarm(0, 23, 58);
      alarmEn = 4'b0001;
      set_cur(23, 57); tick();
      set_cur(23, 58); tick();
      chk("ring_2358", int'(ring), 1);
      snoozeBtn = 1'b1; tick(); snoozeBtn = 1'b0;
      chk("snz_on", int'(snoozing), 1);
      chk("snz_ring", int'(ring), 0);
      set_cur(0, 2); repeat (3) tick();
      chk("snz_0002", int'(ring), 0);
      set_cur(0, 3); tick();
      chk("snz_0003_ring", int'(ring), 1);
      chk("snz_0003_off", int'(snoozing), 0);
      n = 1;
      while (ring && n < 700) begin
         tick();
         if (ring) n++;
      end
      chk("ring_len", n, 600);
      chk("auto_idle", int'(ring) + int'(snoozing), 0);

      // Priority, stop+snooze together, reset out of snooze.
      do_reset();
      set_alarm(0, 6, 0);
      set_alarm(3, 6, 0);
      alarmEn = 4'b1001;
      set_cur(5, 59); tick();
      set_cur(6, 0); tick();
      chk("prio_ring", int'(ring), 1);
      chk("prio_ch", int'(ringCh), 0);
      stopBtn = 1'b1; snoozeBtn = 1'b1; tick(); stopBtn = 1'b0; snoozeBtn = 1'b0;
      chk("both_ring", int'(ring), 0);
      chk("both_snz", int'(snoozing), 0);
      set_cur(5, 59); tick();
      set_cur(6, 0); tick();
      snoozeBtn = 1'b1; tick(); snoozeBtn = 1'b0;
      chk("pre_rst_snz", int'(snoozing), 1);
      sel = 2'd3;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_snz_ring", int'(ring), 0);
      chk("rst_snz_snz", int'(snoozing), 0);
      chk("rst_snz_ch", int'(ringCh), 0);
      chk("rst_snz_alarm", rd_hhmm(), 0);

      // Randomized run against the model.
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
         setM      = ($urandom_range(0, 15) == 0);
         setH      = ($urandom_range(0, 15) == 0);
         stopBtn   = ($urandom_range(0, 29) == 0);
         snoozeBtn = ($urandom_range(0, 19) == 0);
         rst       = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 49) == 0) alarmEn = 4'($urandom);
         k = $urandom_range(0, 39);
         if (k == 0) begin
            n = int'($urandom_range(0, 3));
            n = (m_h[n] * 60 + m_m[n] + 1439) % 1440;
            set_cur(n / 60, n % 60);
         end else if (k < 10) begin
            n = (cur_h * 60 + cur_m + 1) % 1440;
            set_cur(n / 60, n % 60);
         end
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
